// File: rtl/uart_fifo_ctrl.sv
// Pointer and occupancy controller for a DEPTH-entry UART FIFO register file. Accepts are
// combinational and state updates on the next edge; a write while full or a read while empty is refused and flagged.
module uart_fifo_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = (2**ADDR_W) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              wr,
  input  logic              rd,
  input  logic              flush,
  input  logic              err_clr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] r_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

  // Full/empty come from the registered count, so a full FIFO still accepts a same-cycle read.
  assign wr_en = wr & ~full  & ~flush;
  assign rd_en = rd & ~empty & ~flush;

  always_comb begin
    w_addr_d = w_addr_q;
    r_addr_d = r_addr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      w_addr_d = '0;
      r_addr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_en) w_addr_d = w_addr_q + 1'b1;
      if (rd_en) r_addr_d = r_addr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // Setting outranks err_clr so an error in the clearing cycle is not lost.
      if (wr & full)    ovf_d = 1'b1;
      else if (err_clr) ovf_d = 1'b0;
      if (rd & empty)   udf_d = 1'b1;
      else if (err_clr) udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      w_addr_q <= '0;
      r_addr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      w_addr_q <= w_addr_d;
      r_addr_q <= r_addr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign w_addr    = w_addr_q;
  assign r_addr    = r_addr_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
